// File: rtl/vcmdv3_decoder.sv
// Command decoder: turns SPI bytes into framed SET_ADDR / WRITE commands and emits
// one write strobe per data word, auto-incrementing the address.
// Latency: 3-4 Clk from ByteClkIn rise to DataClkOut. There is no backpressure: bytes are
// consumed as they arrive, and bytes seen while DataModeEnable=0 are dropped.
// Ports: Clk/nReset (async, active low); ByteClkIn/ByteIn from the SPI slave;
//        DataModeEnable gates decoding; DataClkOut/AddrOut/DataOut form the write port;
//        Busy = FSM not idle; CmdErr = one-cycle pulse on bad opcode or abort.
// Optional macro VCMD_TIMEOUT_EN: aborts a command after TIMEOUT idle cycles mid-frame.
module vcmdv3_decoder #(
    parameter int AWIDTH  = 18,
    parameter int DWIDTH  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              ByteClkIn,
    input  logic [7:0]        ByteIn,
    input  logic              DataModeEnable,
    output logic              DataClkOut,
    output logic [AWIDTH-1:0] AddrOut,
    output logic [DWIDTH-1:0] DataOut,
    output logic              Busy,
    output logic              CmdErr
);

    localparam int ABYTES = (AWIDTH + 7) / 8;
    localparam int DBYTES = (DWIDTH + 7) / 8;
    localparam logic [3:0] ALAST = 4'(ABYTES - 1);
    localparam logic [3:0] DLAST = 4'(DBYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_COUNT, S_DATA} state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync2_q, sync3_q;
    logic [3:0]        bcnt_q, bcnt_d;
    logic [8:0]        wcnt_q, wcnt_d;
    logic [AWIDTH-1:0] addr_asm_q, addr_asm_d;
    logic [DWIDTH-1:0] data_asm_q, data_asm_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic              strobe_q, strobe_d;
    logic              err_q, err_d;
    logic              byte_vld;
    logic              tmo_hit;

    // ByteClkIn is asynchronous: two flops to resolve metastability, a third to find the edge.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= ByteClkIn;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // An edge that coincides with DataModeEnable low is dropped.
    assign byte_vld = sync2_q & ~sync3_q & DataModeEnable;

`ifdef VCMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt_q;

    assign tmo_hit = DataModeEnable && !byte_vld && (state_q != S_IDLE) &&
                     (tcnt_q == TW'(TIMEOUT - 1));

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            tcnt_q <= '0;
        end else if (byte_vld || (state_q == S_IDLE) || tmo_hit) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_q + TW'(1);
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        wcnt_d     = wcnt_q;
        addr_asm_d = addr_asm_q;
        data_asm_d = data_asm_q;
        addr_d     = addr_q;
        data_d     = data_q;
        strobe_d   = 1'b0;
        err_d      = 1'b0;

        // The post-write increment lands the cycle after the strobe, so AddrOut
        // is still the written address while DataClkOut is high.
        if (strobe_q) begin
            addr_d = addr_q + AWIDTH'(1);
        end

        if (!DataModeEnable) begin
            state_d = S_IDLE;
            bcnt_d  = '0;
        end else if (tmo_hit) begin
            state_d = S_IDLE;
            bcnt_d  = '0;
            err_d   = 1'b1;
        end else if (byte_vld) begin
            unique case (state_q)
                S_IDLE: begin
                    bcnt_d = '0;
                    case (ByteIn)
                        8'h41:   state_d = S_ADDR;
                        8'h42:   state_d = S_COUNT;
                        8'h00:   state_d = S_IDLE;
                        default: err_d   = 1'b1;
                    endcase
                end
                S_ADDR: begin
                    // Shifting MSB first into an AWIDTH register drops excess high bits.
                    addr_asm_d = AWIDTH'({addr_asm_q, ByteIn});
                    if (bcnt_q == ALAST) begin
                        addr_d  = addr_asm_d;
                        bcnt_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        bcnt_d = bcnt_q + 4'd1;
                    end
                end
                S_COUNT: begin
                    wcnt_d  = (ByteIn == 8'h00) ? 9'd256 : {1'b0, ByteIn};
                    bcnt_d  = '0;
                    state_d = S_DATA;
                end
                S_DATA: begin
                    data_asm_d = DWIDTH'({data_asm_q, ByteIn});
                    if (bcnt_q == DLAST) begin
                        data_d   = data_asm_d;
                        strobe_d = 1'b1;
                        bcnt_d   = '0;
                        wcnt_d   = wcnt_q - 9'd1;
                        if (wcnt_q == 9'd1) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bcnt_d = bcnt_q + 4'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= S_IDLE;
            bcnt_q     <= '0;
            wcnt_q     <= '0;
            addr_asm_q <= '0;
            data_asm_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            strobe_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            wcnt_q     <= wcnt_d;
            addr_asm_q <= addr_asm_d;
            data_asm_q <= data_asm_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            strobe_q   <= strobe_d;
            err_q      <= err_d;
        end
    end

    assign DataClkOut = strobe_q;
    assign AddrOut    = addr_q;
    assign DataOut    = data_q;
    assign CmdErr     = err_q;
    assign Busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_vcmdv3_decoder.sv
module tb_vcmdv3_decoder;

    logic        Clk;
    logic        nReset;
    logic        ByteClkIn;
    logic [7:0]  ByteIn;
    logic        DataModeEnable;
    logic        DataClkOut;
    logic [17:0] AddrOut;
    logic [7:0]  DataOut;
    logic        Busy;
    logic        CmdErr;

    vcmdv3_decoder #(.AWIDTH(18), .DWIDTH(8), .TIMEOUT(255)) dut (
        .Clk(Clk),
        .nReset(nReset),
        .ByteClkIn(ByteClkIn),
        .ByteIn(ByteIn),
        .DataModeEnable(DataModeEnable),
        .DataClkOut(DataClkOut),
        .AddrOut(AddrOut),
        .DataOut(DataOut),
        .Busy(Busy),
        .CmdErr(CmdErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a command interpreter working on whole bytes.
    int          m_mode = 0;     // 0 idle, 1 address, 2 count, 3 data
    int          m_k = 0;
    int          m_n = 0;
    int unsigned m_asm = 0;
    int unsigned m_addr = 0;
    int          m_dme = 1;
    int          exp_err = 0;
    logic [25:0] exp_q[$];

    // Observed behaviour collected by the monitor.
    logic [25:0] got_q[$];
    int          got_err = 0;
    logic        prev_strobe = 1'b0;
    logic        prev_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_dme == 0) return;
        case (m_mode)
            0: begin
                if (b == 8'h41) begin m_mode = 1; m_k = 0; m_asm = 0; end
                else if (b == 8'h42) m_mode = 2;
                else if (b != 8'h00) exp_err++;
            end
            1: begin
                m_asm = (m_asm << 8) | b;
                m_k++;
                if (m_k == 3) begin
                    m_addr = m_asm % (1 << 18);
                    m_mode = 0;
                end
            end
            2: begin
                m_n = (b == 0) ? 256 : int'(b);
                m_mode = 3;
            end
            default: begin
                exp_q.push_back({m_addr[17:0], b});
                m_addr = (m_addr + 1) % (1 << 18);
                m_n--;
                if (m_n == 0) m_mode = 0;
            end
        endcase
    endtask

    always @(negedge Clk) begin
        if (nReset) begin
            if (DataClkOut) begin
                chk("strobe_back_to_back", {31'd0, prev_strobe}, 32'd0);
                got_q.push_back({AddrOut, DataOut});
            end
            if (CmdErr) begin
                chk("cmderr_width", {31'd0, prev_err}, 32'd0);
                got_err++;
            end
        end
        prev_strobe = DataClkOut;
        prev_err    = CmdErr;
    end

    // Drive one byte with a raise not aligned to the clock; lat = edges until the strobe.
    task automatic send_byte(input logic [7:0] b, output int lat);
        lat = 0;
        @(negedge Clk);
        #($urandom_range(1, 4));
        ByteIn    = b;
        ByteClkIn = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(posedge Clk);
            #1;
            if (DataClkOut && lat == 0) lat = i;
        end
        ByteClkIn = 1'b0;
        repeat ($urandom_range(3, 6)) @(posedge Clk);
        model_byte(b);
    endtask

    task automatic send(input logic [7:0] b);
        int lat;
        send_byte(b, lat);
    endtask

    task automatic check_state(input string tag);
        repeat (3) @(negedge Clk);
        while (exp_q.size() > 0) begin
            logic [25:0] e;
            e = exp_q.pop_front();
            if (got_q.size() == 0) begin
                chk({tag, "_missing_strobe"}, 32'hDEAD, {6'd0, e});
            end else begin
                chk({tag, "_strobe"}, {6'd0, got_q.pop_front()}, {6'd0, e});
            end
        end
        chk({tag, "_extra_strobes"}, got_q.size(), 0);
        chk({tag, "_cmderr_count"}, got_err, exp_err);
        chk({tag, "_busy"}, {31'd0, Busy}, {31'd0, m_mode != 0});
        chk({tag, "_addr"}, {14'd0, AddrOut}, m_addr);
    endtask

    initial begin
        int lat;
        logic [7:0] r;
        nReset = 1'b0;
        ByteClkIn = 1'b0;
        ByteIn = 8'h00;
        DataModeEnable = 1'b1;
        repeat (3) @(negedge Clk);
        chk("reset_strobe", {31'd0, DataClkOut}, 32'd0);
        chk("reset_addr", {14'd0, AddrOut}, 32'd0);
        chk("reset_data", {24'd0, DataOut}, 32'd0);
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_cmderr", {31'd0, CmdErr}, 32'd0);
        nReset = 1'b1;
        repeat (2) @(negedge Clk);

        // Address with excess high bits.
        send(8'h41); send(8'hFF); send(8'h23); send(8'h45);
        check_state("set_addr");
        chk("set_addr_value", {14'd0, AddrOut}, 32'h32345);

        // Burst across the address wrap point.
        send(8'h41); send(8'h03); send(8'hFF); send(8'hFE);
        send(8'h42); send(8'h03);
        send(8'hC0); send(8'hC1);
        send_byte(8'hC2, lat);
        chk("write_latency_ok", {31'd0, (lat >= 3 && lat <= 4)}, 32'd1);
        check_state("wrap_burst");

        // Count byte 0 means 256 words.
        send(8'h42); send(8'h00);
        for (int i = 0; i < 255; i++) send(8'($urandom));
        chk("busy_before_last", {31'd0, Busy}, 32'd1);
        send(8'($urandom));
        check_state("burst_256");

        // Unknown opcode, then a normal single write.
        send(8'h7E);
        check_state("bad_opcode");
        send(8'h42); send(8'h01); send(8'hAA);
        check_state("after_bad_opcode");

        // Randomised command mix.
        for (int f = 0; f < 12; f++) begin
            case ($urandom_range(0, 3))
                0: begin
                    send(8'h41);
                    for (int j = 0; j < 3; j++) send(8'($urandom));
                end
                1: begin
                    int n;
                    n = $urandom_range(1, 5);
                    send(8'h42); send(8'(n));
                    for (int j = 0; j < n; j++) send(8'($urandom));
                end
                2: begin
                    r = 8'($urandom);
                    while (r == 8'h00 || r == 8'h41 || r == 8'h42) r = 8'($urandom);
                    send(r);
                end
                default: send(8'h00);
            endcase
            check_state("random_frame");
        end

        // DataModeEnable drop mid-burst: abort without error, address kept.
        send(8'h42); send(8'h05); send(8'hAA);
        @(negedge Clk);
        DataModeEnable = 1'b0;
        m_dme = 0;
        m_mode = 0;
        repeat (2) @(negedge Clk);
        chk("dme_off_busy", {31'd0, Busy}, 32'd0);
        send(8'h42);
        send(8'h11);
        check_state("dme_off");
        @(negedge Clk);
        DataModeEnable = 1'b1;
        m_dme = 1;
        send(8'h42); send(8'h01); send(8'h55);
        check_state("dme_back_on");

        // Asynchronous reset mid-burst.
        send(8'h42); send(8'h05); send(8'h11);
        check_state("pre_reset");
        @(posedge Clk);
        #3;
        nReset = 1'b0;
        #1;
        chk("async_rst_strobe", {31'd0, DataClkOut}, 32'd0);
        chk("async_rst_addr", {14'd0, AddrOut}, 32'd0);
        chk("async_rst_busy", {31'd0, Busy}, 32'd0);
        m_mode = 0;
        m_addr = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk("rst_hold_strobe", {31'd0, DataClkOut}, 32'd0);
        end
        nReset = 1'b1;
        send(8'h22);
        check_state("post_reset_data_byte");
        send(8'h42); send(8'h01); send(8'h77);
        check_state("post_reset_write");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
